// File: rtl/mc_bus_driver.sv
// Multicast bus transmit end: sweeps router tags in CONFIG,
// then streams FIFO-buffered tagged words onto the bus in RUN.
module mc_bus_driver #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int NUM_PE     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cfg_start,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  input  logic [ID_WIDTH-1:0]   i_cfg_id,
  output logic                  o_cfg_done,
  output logic                  o_config_state,
  output logic [NUM_PE-1:0]     o_ce,
  output logic [ID_WIDTH-1:0]   o_dest_id,
  input  logic                  i_run_stop,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [ID_WIDTH-1:0]   i_in_tag,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  input  logic                  i_pop_hold,
  output logic [ID_WIDTH-1:0]   o_source_id,
  output logic [DATA_WIDTH-1:0] o_bus_data_out,
  output logic                  o_bus_data_valid
);

  localparam int IW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = ID_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONFIG,
    S_RUN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IW-1:0]         r_idx;
  logic                  r_cfg_done;
  logic                  r_config_state;
  logic [NUM_PE-1:0]     r_ce;
  logic [ID_WIDTH-1:0]   r_dest_id;
  logic                  r_stop;
  logic [EW-1:0]         r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wptr;
  logic [AW:0]           r_rptr;
  logic                  r_bus_valid;
  logic [ID_WIDTH-1:0]   r_source_id;
  logic [DATA_WIDTH-1:0] r_bus_data;

  logic          w_empty;
  logic          w_full;
  logic          w_cfg_acc;
  logic          w_cfg_last;
  logic          w_in_ready;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_rd;

  // extra pointer MSB separates full from empty
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign w_cfg_acc  = (r_state == S_CONFIG) && i_cfg_valid;
  assign w_cfg_last = (r_idx == IW'(NUM_PE - 1));
  assign w_in_ready = (r_state == S_RUN) && !w_full && !r_stop;
  assign w_push     = i_in_valid && w_in_ready;
  assign w_pop      = (r_state == S_RUN) && !w_empty && !i_pop_hold;
  assign w_rd       = r_mem[r_rptr[AW-1:0]];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_cfg_start) w_next = S_CONFIG;
      end
      S_CONFIG: begin
        if (w_cfg_acc && w_cfg_last) w_next = S_RUN;
      end
      S_RUN: begin
        if (r_stop && w_empty && !r_bus_valid)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx          <= '0;
      r_cfg_done     <= 1'b0;
      r_config_state <= 1'b0;
      r_ce           <= '0;
      r_dest_id      <= '0;
    end else begin
      if (r_state == S_IDLE && i_cfg_start)
        r_idx <= '0;
      else if (w_cfg_acc)
        r_idx <= r_idx + IW'(1);
      r_config_state <= w_cfg_acc;
      r_cfg_done     <= w_cfg_acc && w_cfg_last;
      r_ce           <= w_cfg_acc ? (NUM_PE'(1) << r_idx) : '0;
      r_dest_id      <= w_cfg_acc ? i_cfg_id : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_stop <= 1'b0;
    else if (r_state == S_RUN && w_next == S_IDLE)
      r_stop <= 1'b0;
    else if (r_state == S_RUN && i_run_stop)
      r_stop <= 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {i_in_tag, i_in_data};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // bus fields held at zero whenever no word is presented
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bus_valid <= 1'b0;
      r_source_id <= '0;
      r_bus_data  <= '0;
    end else begin
      r_bus_valid <= w_pop;
      r_source_id <= w_pop ? w_rd[EW-1:DATA_WIDTH] : '0;
      r_bus_data  <= w_pop ? w_rd[DATA_WIDTH-1:0] : '0;
    end
  end

  assign o_cfg_ready      = (r_state == S_CONFIG);
  assign o_cfg_done       = r_cfg_done;
  assign o_config_state   = r_config_state;
  assign o_ce             = r_ce;
  assign o_dest_id        = r_dest_id;
  assign o_in_ready       = w_in_ready;
  assign o_source_id      = r_source_id;
  assign o_bus_data_out   = r_bus_data;
  assign o_bus_data_valid = r_bus_valid;

endmodule

// File: tb/tb_mc_bus_driver.sv
// Directed bench for mc_bus_driver: config sweep, streaming,
// full FIFO, run_stop drain and reset flush.
module tb_mc_bus_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_id;
  logic        cfg_done;
  logic        config_state;
  logic [3:0]  ce;
  logic [7:0]  dest_id;
  logic        run_stop;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_tag;
  logic [15:0] in_data;
  logic        pop_hold;
  logic [7:0]  source_id;
  logic [15:0] bus_data;
  logic        bus_valid;

  int nvec = 0;
  int nerr = 0;
  logic [7:0]  rt [4];
  logic [23:0] q [$];

  always #5 clk = ~clk;

  mc_bus_driver #(
    .DATA_WIDTH(16), .ID_WIDTH(8),
    .NUM_PE(4), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cfg_start(cfg_start), .i_cfg_valid(cfg_valid),
    .o_cfg_ready(cfg_ready), .i_cfg_id(cfg_id),
    .o_cfg_done(cfg_done), .o_config_state(config_state),
    .o_ce(ce), .o_dest_id(dest_id),
    .i_run_stop(run_stop), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_in_tag(in_tag),
    .i_in_data(in_data), .i_pop_hold(pop_hold),
    .o_source_id(source_id), .o_bus_data_out(bus_data),
    .o_bus_data_valid(bus_valid)
  );

  task automatic chk(input string t, input logic [31:0] o,
                     input logic [31:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  // router model latches tags from the config strobes; bus words collected
  task automatic tick();
    @(posedge clk);
    #1;
    if (config_state)
      for (int p = 0; p < 4; p++) if (ce[p]) rt[p] = dest_id;
    if (bus_valid) q.push_back({source_id, bus_data});
  endtask

  task automatic chk_all_zero(input string t);
    chk({t, "_outs"},
        {23'd0, cfg_ready, cfg_done, config_state, ce, in_ready, bus_valid}, 0);
    chk({t, "_dest"}, {24'd0, dest_id}, 0);
    chk({t, "_src"}, {24'd0, source_id}, 0);
    chk({t, "_data"}, {16'd0, bus_data}, 0);
  endtask

  initial begin
    int w;
    rst = 1; cfg_start = 0; cfg_valid = 0; cfg_id = 0;
    run_stop = 0; in_valid = 0; in_tag = 0; in_data = 0; pop_hold = 0;
    for (int p = 0; p < 4; p++) rt[p] = 8'hFF;
    tick(); tick();
    chk_all_zero("por");
    rst = 0;

    // config sweep with a one-cycle gap after the second id
    cfg_start = 1; tick(); cfg_start = 0;
    chk("cfg_ready", cfg_ready, 1);
    cfg_valid = 1; cfg_id = 8'h10; tick();
    chk("ce0", {config_state, ce}, 5'b1_0001);
    chk("dest0", dest_id, 8'h10);
    cfg_id = 8'h11; tick();
    chk("ce1", {config_state, ce}, 5'b1_0010);
    chk("dest1", dest_id, 8'h11);
    cfg_valid = 0; cfg_id = 8'h77; tick();
    chk("ce_gap", {config_state, ce, dest_id}, 0);
    cfg_valid = 1; cfg_id = 8'h12; tick();
    chk("ce2", {config_state, ce, cfg_done}, 6'b1_0100_0);
    chk("dest2", dest_id, 8'h12);
    cfg_id = 8'h13; tick(); cfg_valid = 0;
    chk("ce3", {config_state, ce, cfg_done}, 6'b1_1000_1);
    chk("dest3", dest_id, 8'h13);
    chk("run_entry", {cfg_ready, in_ready}, 2'b01);
    tick();
    chk("cfg_end", {cfg_done, config_state, ce}, 0);
    chk("rt_tags", {rt[0], rt[1], rt[2], rt[3]}, 32'h10111213);

    // single word latency and router match
    q.delete();
    in_valid = 1; in_tag = 8'h11; in_data = 16'hBEEF; tick();
    in_valid = 0;
    chk("lat_e", bus_valid, 0);
    tick();
    chk("lat_e1", {bus_valid, source_id, bus_data}, {1'b1, 8'h11, 16'hBEEF});
    chk("rt1_hit", (rt[1] == source_id), 1);
    chk("rt2_miss", (rt[2] == source_id), 0);
    tick();
    chk("lat_gone", {bus_valid, source_id, bus_data}, 0);
    chk("lat_cnt", q.size(), 1);

    // ten-word stream
    q.delete();
    for (int i = 0; i < 13; i++) begin
      in_valid = (i < 10);
      in_tag = 8'h20 + 8'(i);
      in_data = 16'h1000 + 16'(i);
      if (i < 10) chk("strm_rdy", in_ready, 1);
      tick();
    end
    in_valid = 0;
    chk("strm_cnt", q.size(), 10);
    for (int i = 0; i < 10; i++)
      chk("strm_word", q[i], {8'h20 + 8'(i), 16'h1000 + 16'(i)});

    // fill with pops inhibited, then release
    q.delete();
    pop_hold = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1;
      in_tag = 8'h30 + 8'((i < 4) ? i : 4);
      in_data = 16'h3000 + 16'((i < 4) ? i : 4);
      chk("full_rdy", in_ready, (i < 4) ? 1 : 0);
      tick();
      chk("full_nobus", bus_valid, 0);
    end
    pop_hold = 0;
    w = 4;
    for (int j = 0; j < 14; j++) begin
      in_valid = (w < 6);
      in_tag = 8'h30 + 8'(w);
      in_data = 16'h3000 + 16'(w);
      if (in_valid && in_ready) begin
        tick(); w++;
      end else tick();
    end
    in_valid = 0;
    chk("full_cnt", q.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("full_word", q[i], {8'h30 + 8'(i), 16'h3000 + 16'(i)});

    // run_stop drains buffered words then returns to idle
    q.delete();
    pop_hold = 1;
    in_valid = 1; in_tag = 8'h40; in_data = 16'h4000; tick();
    in_tag = 8'h41; in_data = 16'h4001; tick();
    in_valid = 0; run_stop = 1; tick();
    run_stop = 0; pop_hold = 0;
    chk("stop_rdy", in_ready, 0);
    for (int j = 0; j < 6; j++) begin
      in_valid = 1; in_tag = 8'h4F; in_data = 16'hDEAD;
      tick();
      chk("stop_blk", in_ready, 0);
    end
    in_valid = 0;
    chk("stop_cnt", q.size(), 2);
    chk("stop_w0", q[0], 24'h40_4000);
    chk("stop_w1", q[1], 24'h41_4001);
    chk("stop_idle", cfg_ready, 0);
    cfg_start = 1; tick(); cfg_start = 0;
    chk("stop_recfg", cfg_ready, 1);

    // reset mid-run with three words buffered
    cfg_valid = 1;
    for (int i = 0; i < 4; i++) begin
      cfg_id = 8'h50 + 8'(i); tick();
    end
    cfg_valid = 0;
    chk("rst_run", in_ready, 1);
    pop_hold = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_tag = 8'h60 + 8'(i); in_data = 16'h6000; tick();
    end
    in_valid = 0;
    q.delete();
    rst = 1; pop_hold = 0; in_valid = 1; cfg_start = 1;
    tick(); tick();
    chk_all_zero("rst_mid");
    rst = 0; in_valid = 0; cfg_start = 0;
    for (int j = 0; j < 4; j++) tick();
    chk("rst_nobus", q.size(), 0);
    chk("rst_idle", {cfg_ready, in_ready, ce}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
